// File: rtl/seg7_scan_mux_pkg.sv
// Shared types and constants for the four-digit multiplexed seven-segment driver.
// Covers FSM encodings, the digit record, the hex-to-segment table and the blank code.
package seg7_scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       dp;
    } digit_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low gfedcba with the dp bit (bit 7) dark; index = hex value.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam digit_t DIGIT_BLANK = '{value: 4'h0, blank: 1'b1, dp: 1'b0};

endpackage

// File: rtl/seg7_scan_mux_hex_decode.sv
// Combinational hex digit to active-low segment pattern, with decimal point and blanking.
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = HEX_SEG[value] & {~dp, 7'h7F};
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit scan multiplexer: double-buffered digit writes, guard-banded digit switching
// and PWM dimming of the active anode.
//
// state    | meaning
// ST_IDLE  | no tick seen since reset, display dark
// ST_GUARD | all anodes off while segments settle after a digit switch
// ST_ON    | digit idx driven, anode gated by PWM compare
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int DIM_BITS     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_display,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [3:0]          wr_value,
    input  logic                wr_blank,
    input  logic                wr_dp,
    input  logic [DIM_BITS-1:0] brightness,
    output logic [3:0]          anodos,
    output logic [7:0]          segmentos
);

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_t              state, state_nxt;
    logic [3:0]          guard_cnt, guard_nxt;
    logic [1:0]          idx;
    logic [DIM_BITS-1:0] pwm_cnt;
    logic [1:0]          wr_ptr;
    logic [2:0]          count;
    digit_t [3:0]        shadow;
    digit_t [3:0]        display;
    digit_t              cur_digit;
    logic [7:0]          seg_cur;
    logic [3:0]          ano_nxt;
    logic [7:0]          seg_nxt;
    logic                commit;

    assign wr_ready  = (count < 3'd4);
    assign commit    = tick_display && (idx == 2'd3) && (count == 3'd4);
    assign cur_digit = display[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_nxt;
        end
    end

    // Guard timer is a down-counter; a tick anywhere past IDLE restarts it.
    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        case (state)
            ST_IDLE: begin
                if (tick_display) begin
                    state_nxt = ST_GUARD;
                    guard_nxt = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                if (tick_display) begin
                    guard_nxt = GUARD_LOAD;
                end else if (guard_cnt == 4'd0) begin
                    state_nxt = ST_ON;
                end else begin
                    guard_nxt = guard_cnt - 4'd1;
                end
            end
            ST_ON: begin
                if (tick_display) begin
                    state_nxt = ST_GUARD;
                    guard_nxt = GUARD_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                guard_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DIM_BITS'(1);
            if (tick_display) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // wr_ready is low whenever commit can fire, so a write never coincides with a commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            count   <= '0;
            shadow  <= {4{DIGIT_BLANK}};
            display <= {4{DIGIT_BLANK}};
        end else if (commit) begin
            display <= shadow;
            wr_ptr  <= '0;
            count   <= '0;
        end else if (wr_valid && wr_ready) begin
            shadow[wr_ptr] <= '{value: wr_value, blank: wr_blank, dp: wr_dp};
            wr_ptr         <= wr_ptr + 2'd1;
            count          <= count + 3'd1;
        end
    end

    seg7_hex_decode u_decode (
        .value (cur_digit.value),
        .dp    (cur_digit.dp),
        .blank (cur_digit.blank),
        .seg   (seg_cur)
    );

    // Only anodos[idx] can ever be cleared, so at most one digit is enabled.
    always_comb begin
        ano_nxt = 4'hF;
        seg_nxt = SEG_BLANK;
        if (state == ST_ON) begin
            seg_nxt = seg_cur;
            if ((pwm_cnt <= brightness) && !cur_digit.blank) begin
                ano_nxt[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anodos    <= 4'hF;
            segmentos <= SEG_BLANK;
        end else begin
            anodos    <= ano_nxt;
            segmentos <= seg_nxt;
        end
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 The block SHALL have parameter GUARD_CYCLES, default 2, meaning the all-anodes-off cycles after each digit switch (range 1..15).
REQ-002 The block SHALL have parameter DIM_BITS, default 3, meaning the PWM counter and brightness width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous active-low reset
 tick_display  in  1  one-clk strobe advancing the scan digit
 wr_valid  in  1  digit-write request
 wr_ready  out  1  shadow buffer can accept a write
 wr_value  in  4  hex digit value
 wr_blank  in  1  digit is dark
 wr_dp  in  1  decimal point lit
 brightness  in  DIM_BITS  duty select, all-ones = full on
 anodos  out  4  active-low digit enables, bit i = digit i
 segmentos  out  8  active-low, [6:0]=gfedcba, [7]=dp

Function
REQ-004 A write SHALL occur on a clk edge with wr_valid=1 and wr_ready=1, storing {value,blank,dp} into shadow slot wr_ptr; wr_ptr SHALL then increment.
REQ-005 wr_ready SHALL equal (shadow count < 4); after the 4th write it SHALL be 0 on the next cycle.
REQ-006 The 2-bit scan index SHALL advance on tick_display, wrapping 3->0.
REQ-007 On a tick that wraps the index 3->0 with shadow count = 4, all four shadow slots SHALL be copied to the display buffer, and count and wr_ptr SHALL clear, so wr_ready=1 on the following cycle.
REQ-008 On a wrap with count < 4, the display buffer SHALL be unchanged and the partial shadow contents SHALL be retained.
REQ-009 The FSM SHALL have states IDLE, GUARD and ON: IDLE->GUARD on the first tick; GUARD->ON after GUARD_CYCLES clks; any tick in GUARD or ON SHALL re-enter GUARD with the guard counter restarted.
REQ-010 In IDLE and GUARD, anodos SHALL be 4'hF and segmentos SHALL be 8'hFF.
REQ-011 A DIM_BITS free-running PWM counter SHALL increment every clk and wrap.
REQ-012 In ON, anodos[idx] SHALL be 0 iff pwm_cnt <= brightness and the digit is not blanked; otherwise anodos SHALL be 4'hF.
REQ-013 segmentos SHALL be the standard hex decode of the display-buffer digit at idx: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (dp off); dp=1 SHALL clear bit 7. A blanked digit SHALL give 8'hFF.
REQ-014 anodos and segmentos SHALL be registered; the output SHALL change 1 clk after the state or index change that causes it.
REQ-015 No two anodos bits SHALL ever be low together.

Reset
REQ-016 The following SHALL apply when rst is low: anodos=4'hF, segmentos=8'hFF, wr_ready=1, FSM=IDLE, idx=0, pwm_cnt=0, wr_ptr=0, count=0, and all display and shadow slots blank=1.
REQ-017 Reset asserted mid-scan or mid-fill SHALL force the reset values immediately; a partial shadow fill SHALL be discarded.

Structure
REQ-018 A shared package/include SHALL hold the FSM state encodings, the 16-entry hex-to-segment table and the blank code 8'hFF.
REQ-019 Hex decode SHALL be one combinational sub-module, seg7_hex_decode (value, dp, blank -> seg[7:0]).

Verification
REQ-020 Reset, then write 1,2,3,4 (dp=0) and issue 4 ticks: the commit occurs on the 4th tick, and digits 0..3 then show F9, A4, B0, 99 on successive ticks.
REQ-021 Write 5 digits back-to-back: wr_ready=0 after the 4th, the 5th is held until the commit, and it is then accepted into slot 0.
REQ-022 With brightness=3 and DIM_BITS=3 in ON: the anode is low exactly 4 of every 8 clks; with brightness=7 it is low 8 of 8.
REQ-023 A tick arriving 1 clk into GUARD with GUARD_CYCLES=2: anodos stays F for 2 full clks after the second tick, and idx advances twice.
REQ-024 Write value 8 with dp=1 and value 0 with blank=1: segmentos is 8'h00 for the first; for the second its anode stays high and segmentos is FF.
REQ-025 Assert rst during ON with shadow count=2: outputs are F/FF within the same cycle, and after release wr_ready=1 and 4 more writes are needed for a commit.
